// File: rtl/pipelined_lac_adder.sv
// Three-stage pipelined carry-lookahead adder/subtractor with status flags
// and a valid/ready handshake. Leaf lookahead cells of LEAF bits feed a
// radix-2 parallel-prefix tree that produces every carry from c0.
module pipelined_lac_adder #(
    parameter int WIDTH = 32,
    parameter int LEAF  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / LEAF;

    if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipelined_lac_adder: WIDTH must be a power of two in 4..64");
    end
    if (LEAF < 1 || LEAF > WIDTH || (LEAF & (LEAF - 1)) != 0) begin : g_bad_leaf
        $error("pipelined_lac_adder: LEAF must be a power of two no larger than WIDTH");
    end

    logic             adv1, adv2, adv3;
    logic             v1, v2, v3;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g1, p1;
    logic             c0_1;
    logic [WIDTH:0]   c2;
    logic [WIDTH-1:0] p2;
    logic [NG-1:0]    grp_g, grp_p, grp_c;
    logic [WIDTH:0]   carry;

    // Ready chain: an empty stage always accepts, so bubbles collapse.
    always_comb begin
        adv3     = ~v3 | out_ready;
        adv2     = ~v2 | adv3;
        adv1     = ~v1 | adv2;
        in_ready = adv1;
        bx       = b ^ {WIDTH{sub}};
    end

    // Stage valid bits; each stage holds when its advance is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1) v1 <= in_valid;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
        end
    end

    // S1: bitwise generate/propagate of the transformed operands.
    always_ff @(posedge clk) begin
        if (adv1) begin
            g1   <= a & bx;
            p1   <= a ^ bx;
            c0_1 <= cin ^ sub;
        end
    end

    // Leaf group g/p, radix-2 prefix over groups, then per-bit carries.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        carry = '0;
        for (int k = 0; k < NG; k++) begin
            grp_p[k] = 1'b1;
            for (int j = 0; j < LEAF; j++) begin
                grp_g[k] = g1[k*LEAF+j] | (p1[k*LEAF+j] & grp_g[k]);
                grp_p[k] = grp_p[k] & p1[k*LEAF+j];
            end
        end
        // Descending update keeps grp_*[k-d] at its previous-level value.
        for (int d = 1; d < NG; d = d * 2) begin
            for (int k = NG - 1; k >= d; k--) begin
                grp_g[k] = grp_g[k] | (grp_p[k] & grp_g[k-d]);
                grp_p[k] = grp_p[k] & grp_p[k-d];
            end
        end
        grp_c[0] = c0_1;
        for (int k = 1; k < NG; k++) begin
            grp_c[k] = grp_g[k-1] | (grp_p[k-1] & c0_1);
        end
        for (int k = 0; k < NG; k++) begin
            carry[k*LEAF] = grp_c[k];
            for (int j = 0; j < LEAF; j++) begin
                carry[k*LEAF+j+1] = g1[k*LEAF+j] | (p1[k*LEAF+j] & carry[k*LEAF+j]);
            end
        end
    end

    // S2: register the full carry vector alongside propagate.
    always_ff @(posedge clk) begin
        if (adv2) begin
            c2 <= carry;
            p2 <= p1;
        end
    end

    // S3: result and flags; a bubble loads zeros so idle outputs read 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (adv3) begin
            if (v2) begin
                sum  <= p2 ^ c2[WIDTH-1:0];
                cout <= c2[WIDTH];
                ovf  <= c2[WIDTH] ^ c2[WIDTH-1];
                zero <= ~|(p2 ^ c2[WIDTH-1:0]);
            end else begin
                sum  <= '0;
                cout <= 1'b0;
                ovf  <= 1'b0;
                zero <= 1'b0;
            end
        end
    end

    assign out_valid = v3;

endmodule
